sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Single-port arbiter sharing the user-project custom SRAM (512 × 32-bit, synchronous read) between three requesters: the Wishbone slave port from the management SoC, the Elpis core data port, and the Elpis core instruction-fetch port. It sits between the core, the Wishbone slave logic and the SRAM macro inside the user project. It issues at most one SRAM access per cycle and returns read data one cycle after grant. It also provides a hold input so firmware can load program memory over Wishbone while the core is stalled.

## Interface
Parameters:
- ADDR_W, 9, SRAM word-address width
- DATA_W, 32, data width; byte-lane count is DATA_W/8
- STARVE_LIM, 4, consecutive denied cycles after which the instruction port is forced to win one grant

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- core_hold  in  1  when 1, neither core port is granted; Wishbone only
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address; bits [ADDR_W+1:2] index the SRAM; region decode is done upstream
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data, valid with ack
- dm_req, dm_we  in  1 each  data-port request / write
- dm_be  in  4  byte enables
- dm_addr  in  ADDR_W  word address
- dm_wdata  in  DATA_W  write data
- dm_gnt  out  1  combinational grant
- dm_rvalid  out  1  response strobe, cycle after grant, for both reads and writes
- dm_rdata  out  DATA_W  read data
- im_req  in  1  instruction-fetch request (read only)
- im_addr  in  ADDR_W  word address
- im_gnt, im_rvalid  out  1 each  grant / response strobe
- im_rdata  out  DATA_W  fetch data
- sram_csb, sram_web  out  1 each  active-low chip select / write enable to the macro
- sram_wmask  out  4  byte write mask
- sram_addr  out  ADDR_W  address
- sram_din  out  DATA_W  write data
- sram_dout  in  DATA_W  macro read data, valid the cycle after csb low

## Operation
- Eligible requesters in a cycle:
  - WB: wbs_cyc_i & wbs_stb_i & wb FSM in WB_IDLE.
  - DM: dm_req & ~core_hold.
  - IM: im_req & ~core_hold.
- Fixed priority: WB > DM > IM.
- Anti-starvation override:
  - starve_cnt counts cycles in which IM is eligible but not granted.
  - When starve_cnt == STARVE_LIM and IM is eligible, IM wins over DM; WB keeps precedence.
  - starve_cnt clears on any IM grant, or when IM is not eligible. It saturates at STARVE_LIM.
- Grant cycle:
  - Drive sram_csb=0 with the winner's address, data and mask.
  - sram_web=0 for writes.
  - For IM, and for reads, sram_wmask is a don't-care and is driven as 0.
  - Register the owner (NONE/WB/DM/IM).
- Response cycle, one cycle after grant:
  - Assert the owner's rvalid or wbs_ack_o.
  - Route sram_dout to that owner's rdata. Other rdata outputs hold their last value.
- Wishbone FSM:
  - WB_IDLE → WB_ACK on a WB grant.
  - WB_ACK asserts wbs_ack_o for exactly one cycle, then returns to WB_IDLE.
  - No WB grant while in WB_ACK, even though stb is still high. A new strobe is sampled from WB_IDLE.
- Only one access is granted per cycle. Back-to-back grants to the same core port are allowed: a new grant can coincide with the previous response.
- Idle (no grant): sram_csb=1, sram_web=1; address and data hold their previous values.
- core_hold asserted mid-stream: an already-granted access still gets its response; only new core grants are blocked.
- Reset (async, any time):
  - All outputs take their reset values; owner returns to NONE; wb FSM returns to WB_IDLE; starve_cnt returns to 0.
  - In-flight responses are dropped.

## Timing
- Reset values: wbs_ack_o=0, dm_rvalid=0, im_rvalid=0, sram_csb=1, sram_web=1, sram_wmask=0, all data/address outputs 0. dm_gnt and im_gnt are 0 while rst_n is low.
- Grants are combinational from requests in the same cycle. Requesters must hold address, data and request until they see the grant.
- Latency is fixed: response (rvalid or ack) exactly 1 cycle after grant.
- Wishbone throughput: at most one access every 2 cycles.
- Core throughput: one access per cycle when uncontended.

## Structure
- Package sram_arb_pkg holds:
  - the owner_t enum (OWN_NONE, OWN_WB, OWN_DM, OWN_IM);
  - the wb FSM state enum (WB_IDLE, WB_ACK);
  - default ADDR_W/DATA_W constants.
- One sub-module, sram_arb_select: the combinational priority and starvation-override selector, producing a one-hot grant. The top holds all registers (owner, wb FSM, starve_cnt) and the SRAM output mux.

## Test plan
- WB write 0xDEADBEEF to word 5 (sel=4'hF), then WB read of word 5 → ack one cycle after each grant; read returns 0xDEADBEEF; exactly one ack per strobe.
- DM and IM request simultaneously with core_hold=0 → DM granted first; IM granted the next cycle; rvalids arrive on consecutive cycles carrying the correct words.
- DM requests continuously while IM requests → IM is forced a grant after 4 denied cycles; starve_cnt returns to 0.
- core_hold=1 with DM and IM requesting and a WB write in progress → no core grants; WB completes; releasing hold grants DM the same cycle.
- WB strobe held high across the ack cycle → no second SRAM access (sram_csb stays 1 in the ack cycle).
- rst_n pulsed low in the cycle after a DM read grant → dm_rvalid stays 0; sram_csb=1; all outputs at their reset values; normal operation resumes after release.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the user-project SRAM port arbiter.
package sram_arb_pkg;

    localparam int ADDR_W_DEF     = 9;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_LIM_DEF = 4;

    // Bit positions inside the one-hot grant vector.
    localparam int GNT_WB = 0;
    localparam int GNT_DM = 1;
    localparam int GNT_IM = 2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_WB   = 2'd1,
        OWN_DM   = 2'd2,
        OWN_IM   = 2'd3
    } owner_t;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_t;

    function automatic owner_t gnt_to_owner(input logic [2:0] gnt);
        owner_t own;
        own = OWN_NONE;
        if (gnt[GNT_WB]) begin
            own = OWN_WB;
        end else if (gnt[GNT_DM]) begin
            own = OWN_DM;
        end else if (gnt[GNT_IM]) begin
            own = OWN_IM;
        end
        return own;
    endfunction

endpackage

// File: rtl/sram_arb_select.sv
// Combinational winner selection: Wishbone first, then data port, then fetch,
// except that a starved fetch port jumps ahead of the data port.
module sram_arb_select
    import sram_arb_pkg::*;
(
    input  logic       i_wb_elig,
    input  logic       i_dm_elig,
    input  logic       i_im_elig,
    input  logic       i_im_starved,
    output logic [2:0] o_gnt
);

    always_comb begin
        o_gnt = 3'b000;
        if (i_wb_elig) begin
            o_gnt[GNT_WB] = 1'b1;
        end else if (i_im_elig && i_im_starved) begin
            o_gnt[GNT_IM] = 1'b1;
        end else if (i_dm_elig) begin
            o_gnt[GNT_DM] = 1'b1;
        end else if (i_im_elig) begin
            o_gnt[GNT_IM] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the single-port user-project SRAM between the Wishbone slave, the Elpis
// data port and the Elpis fetch port: one access per cycle, response one cycle later.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                core_hold,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [DATA_W/8-1:0] wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [DATA_W-1:0]   wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [DATA_W-1:0]   wbs_dat_o,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    input  logic                im_req,
    input  logic [ADDR_W-1:0]   im_addr,
    output logic                im_gnt,
    output logic                im_rvalid,
    output logic [DATA_W-1:0]   im_rdata,
    output logic                sram_csb,
    output logic                sram_web,
    output logic [DATA_W/8-1:0] sram_wmask,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_din,
    input  logic [DATA_W-1:0]   sram_dout,
    output logic                o_dbg_wb_state,
    output logic [1:0]          o_dbg_owner
);

    // Handshake: a requester holds req/address/data stable until it sees its grant in
    // the same cycle; the response strobe (rvalid or ack) follows exactly one cycle later.

    localparam int SC_W = $clog2(STARVE_LIM + 1);

    wb_state_t         r_wb_state;
    wb_state_t         w_wb_state_nxt;
    owner_t            r_owner;
    logic [SC_W-1:0]   r_starve_cnt;
    logic [SC_W-1:0]   w_starve_nxt;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_din;
    logic [DATA_W-1:0] r_wb_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic [DATA_W-1:0] r_im_rdata;

    logic              w_wb_elig;
    logic              w_dm_elig;
    logic              w_im_elig;
    logic              w_im_starved;
    logic [2:0]        w_gnt;
    logic              w_unused;

    // Region decode happens upstream, so the byte offset and high address bits are ignored.
    assign w_unused = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

    // rst_n gates eligibility so no grant (and no SRAM select) escapes during reset.
    assign w_wb_elig    = rst_n & wbs_cyc_i & wbs_stb_i & (r_wb_state == WB_IDLE);
    assign w_dm_elig    = rst_n & dm_req & ~core_hold;
    assign w_im_elig    = rst_n & im_req & ~core_hold;
    assign w_im_starved = (r_starve_cnt == SC_W'(STARVE_LIM));

    sram_arb_select u_select (
        .i_wb_elig    (w_wb_elig),
        .i_dm_elig    (w_dm_elig),
        .i_im_elig    (w_im_elig),
        .i_im_starved (w_im_starved),
        .o_gnt        (w_gnt)
    );

    assign dm_gnt = w_gnt[GNT_DM];
    assign im_gnt = w_gnt[GNT_IM];

    always_comb begin
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_wmask = '0;
        sram_addr  = r_sram_addr;
        sram_din   = r_sram_din;
        if (w_gnt[GNT_WB]) begin
            sram_csb   = 1'b0;
            sram_web   = ~wbs_we_i;
            sram_wmask = wbs_we_i ? wbs_sel_i : '0;
            sram_addr  = wbs_adr_i[ADDR_W+1:2];
            sram_din   = wbs_dat_i;
        end else if (w_gnt[GNT_DM]) begin
            sram_csb   = 1'b0;
            sram_web   = ~dm_we;
            sram_wmask = dm_we ? dm_be : '0;
            sram_addr  = dm_addr;
            sram_din   = dm_wdata;
        end else if (w_gnt[GNT_IM]) begin
            sram_csb   = 1'b0;
            sram_addr  = im_addr;
        end
    end

    // Starvation only accumulates while fetch is eligible and losing; it saturates at the limit.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!w_im_elig || w_gnt[GNT_IM]) begin
            w_starve_nxt = '0;
        end else if (!w_im_starved) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= OWN_NONE;
            r_starve_cnt <= '0;
            r_sram_addr  <= '0;
            r_sram_din   <= '0;
            r_wb_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_im_rdata   <= '0;
        end else begin
            r_owner      <= gnt_to_owner(w_gnt);
            r_starve_cnt <= w_starve_nxt;
            r_sram_addr  <= sram_addr;
            r_sram_din   <= sram_din;
            if (r_owner == OWN_WB) begin
                r_wb_rdata <= sram_dout;
            end
            if (r_owner == OWN_DM) begin
                r_dm_rdata <= sram_dout;
            end
            if (r_owner == OWN_IM) begin
                r_im_rdata <= sram_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_state <= WB_IDLE;
        end else begin
            r_wb_state <= w_wb_state_nxt;
        end
    end

    // The ack cycle blocks re-granting a strobe the master has not yet dropped.
    always_comb begin
        w_wb_state_nxt = r_wb_state;
        case (r_wb_state)
            WB_IDLE: if (w_gnt[GNT_WB]) w_wb_state_nxt = WB_ACK;
            WB_ACK:  w_wb_state_nxt = WB_IDLE;
            default: w_wb_state_nxt = WB_IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o = (r_wb_state == WB_ACK);
    end

    assign dm_rvalid = (r_owner == OWN_DM);
    assign im_rvalid = (r_owner == OWN_IM);

    assign wbs_dat_o = wbs_ack_o ? sram_dout : r_wb_rdata;
    assign dm_rdata  = dm_rvalid ? sram_dout : r_dm_rdata;
    assign im_rdata  = im_rvalid ? sram_dout : r_im_rdata;

    assign o_dbg_wb_state = r_wb_state;
    assign o_dbg_owner    = r_owner;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM macro model, directed scenarios, randomized traffic
// against a reference arbitration/memory model, and a response scoreboard.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int NB  = DW / 8;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_hold = 1'b0;
    logic          wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [NB-1:0] wbs_sel_i = '0;
    logic [31:0]   wbs_adr_i = '0;
    logic [DW-1:0] wbs_dat_i = '0;
    logic          wbs_ack_o;
    logic [DW-1:0] wbs_dat_o;
    logic          dm_req = 1'b0, dm_we = 1'b0;
    logic [NB-1:0] dm_be = '0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_gnt, dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          im_req = 1'b0;
    logic [AW-1:0] im_addr = '0;
    logic          im_gnt, im_rvalid;
    logic [DW-1:0] im_rdata;
    logic          sram_csb, sram_web;
    logic [NB-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout = '0;
    logic          dbg_wb_state;
    logic [1:0]    dbg_owner;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .core_hold(core_hold),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt), .im_rvalid(im_rvalid),
        .im_rdata(im_rdata),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
        .o_dbg_wb_state(dbg_wb_state), .o_dbg_owner(dbg_owner)
    );

    // SRAM macro: synchronous read, byte-masked write
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < NB; b++) begin
                    if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
                end
            end else begin
                sram_dout <= sram_mem[sram_addr];
            end
        end
    end

    // Reference model and scoreboard state. Port codes: 0 none, 1 WB, 2 DM, 3 IM.
    typedef struct {
        int            due;
        int            port;
        logic          chk;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            starve = 0;
    logic          wb_ack_cyc = 1'b0;
    logic          wb_pend = 1'b0, dm_pend = 1'b0, im_pend = 1'b0;
    logic          mon_en = 1'b0;
    int            cyc_cnt = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Monitor: at most one response can be due per cycle since only one grant is issued.
    initial begin
        forever begin
            logic [2:0]    exp_v;
            logic [DW-1:0] act_d;
            exp_t          e;
            @(posedge clk);
            #1;
            if (mon_en) begin
                exp_v = 3'b000;
                if (exp_q.size() > 0 && exp_q[0].due == cyc_cnt) begin
                    e = exp_q.pop_front();
                    case (e.port)
                        1: begin exp_v = 3'b100; act_d = wbs_dat_o; end
                        2: begin exp_v = 3'b010; act_d = dm_rdata;  end
                        default: begin exp_v = 3'b001; act_d = im_rdata; end
                    endcase
                    check("resp_strobe", 64'({wbs_ack_o, dm_rvalid, im_rvalid}), 64'(exp_v));
                    if (e.chk) check("resp_data", 64'(act_d), 64'(e.data));
                end else if (wbs_ack_o || dm_rvalid || im_rvalid) begin
                    check("resp_strobe", 64'({wbs_ack_o, dm_rvalid, im_rvalid}), 64'(exp_v));
                end
            end
        end
    end

    task automatic cycle_begin();
        @(negedge clk);
    endtask

    // Decide the winner from the rules, compare the grant and SRAM pins, push the response.
    task automatic cycle_check();
        logic          wb_e, dm_e, im_e, we_x;
        int            win;
        logic [AW-1:0] a;
        logic [NB-1:0] m;
        logic [DW-1:0] d;
        exp_t          e;
        #1;
        wb_e = rst_n && wbs_cyc_i && wbs_stb_i && !wb_ack_cyc;
        dm_e = rst_n && dm_req && !core_hold;
        im_e = rst_n && im_req && !core_hold;
        if (wb_e)                      win = 1;
        else if (im_e && starve >= LIM) win = 3;
        else if (dm_e)                 win = 2;
        else if (im_e)                 win = 3;
        else                           win = 0;
        check("arb_gnt_csb", 64'({dm_gnt, im_gnt, sram_csb}), 64'({win == 2, win == 3, win == 0}));
        if (win != 0) begin
            case (win)
                1: begin a = wbs_adr_i[AW+1:2]; we_x = wbs_we_i; m = wbs_sel_i; d = wbs_dat_i; end
                2: begin a = dm_addr; we_x = dm_we; m = dm_be; d = dm_wdata; end
                default: begin a = im_addr; we_x = 1'b0; m = '0; d = '0; end
            endcase
            check("sram_ctl", 64'({sram_addr, sram_web, sram_wmask}), 64'({a, !we_x, we_x ? m : 4'h0}));
            if (we_x) check("sram_din", 64'(sram_din), 64'(d));
            e.due  = cyc_cnt + 1;
            e.port = win;
            e.chk  = !we_x;
            e.data = ref_mem[a];
            exp_q.push_back(e);
            if (we_x) begin
                for (int b = 0; b < NB; b++) begin
                    if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
                end
            end
        end else begin
            check("sram_idle_web", 64'(sram_web), 64'(1));
        end
        starve     = (im_e && win != 3) ? ((starve < LIM) ? starve + 1 : LIM) : 0;
        wb_ack_cyc = (win == 1);
        if (win == 1) wb_pend = 1'b0;
        if (win == 2) dm_pend = 1'b0;
        if (win == 3) im_pend = 1'b0;
    endtask

    task automatic step();
        cycle_begin();
        cycle_check();
    endtask

    task automatic idle_inputs();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; dm_req = 1'b0; im_req = 1'b0; core_hold = 1'b0;
        wb_pend = 1'b0; dm_pend = 1'b0; im_pend = 1'b0;
    endtask

    task automatic wb_set(input logic we, input int word, input logic [DW-1:0] dat, input logic [NB-1:0] sel);
        logic [31:0] adr;
        adr = $urandom();
        adr[AW+1:2] = AW'(word);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    endtask

    task automatic drive_random();
        if ($urandom_range(0, 15) == 0) core_hold = ~core_hold;
        if (!wb_ack_cyc && !wb_pend) begin
            if ($urandom_range(0, 3) == 0) begin
                wb_set(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom(), NB'($urandom_range(1, 15)));
                wb_pend = 1'b1;
            end else begin
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
        end
        if (!dm_pend) begin
            if ($urandom_range(0, 3) != 0) begin
                dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_be = NB'($urandom_range(1, 15));
                dm_addr = AW'($urandom_range(0, 31)); dm_wdata = $urandom(); dm_pend = 1'b1;
            end else begin
                dm_req = 1'b0;
            end
        end
        if (!im_pend) begin
            if ($urandom_range(0, 2) != 0) begin
                im_req = 1'b1; im_addr = AW'($urandom_range(0, 31)); im_pend = 1'b1;
            end else begin
                im_req = 1'b0;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnts"},  64'({dm_gnt, im_gnt}), 64'(0));
        check({tag, "_resp"},  64'({wbs_ack_o, dm_rvalid, im_rvalid}), 64'(0));
        check({tag, "_csb_web"}, 64'({sram_csb, sram_web}), 64'(2'b11));
        check({tag, "_wmask"}, 64'(sram_wmask), 64'(0));
        check({tag, "_addr"},  64'(sram_addr), 64'(0));
        check({tag, "_din"},   64'(sram_din), 64'(0));
        check({tag, "_rdata"}, 64'(wbs_dat_o | dm_rdata | im_rdata), 64'(0));
        check({tag, "_wbfsm"}, 64'(dbg_wb_state), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_im;
        for (int i = 0; i < (1 << AW); i++) begin
            logic [DW-1:0] v;
            v = $urandom();
            sram_mem[i] = v;
            ref_mem[i]  = v;
        end
        // Requests present during reset must not be granted.
        dm_req = 1'b1; im_req = 1'b1; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        idle_inputs();
        rst_n = 1'b1;
        mon_en = 1'b1;

        // WB write then read of word 5, strobe held across each ack cycle.
        cycle_begin(); wb_set(1'b1, 5, 32'hDEADBEEF, 4'hF); cycle_check();
        step();
        cycle_begin(); wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; cycle_check();
        cycle_begin(); wb_set(1'b0, 5, '0, 4'hF); cycle_check();
        step();
        cycle_begin(); wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; cycle_check();
        check("wb_readback_ref", 64'(ref_mem[5]), 64'(32'hDEADBEEF));

        // DM and IM together: DM first, IM next cycle.
        cycle_begin(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'd7; im_req = 1'b1; im_addr = 9'd9; cycle_check();
        cycle_begin(); dm_req = 1'b0; cycle_check();
        cycle_begin(); im_req = 1'b0; cycle_check();
        step();

        // DM streaming while IM waits: IM forced in on its fifth cycle of waiting.
        first_im = -1;
        im_pend = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycle_begin();
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = AW'($urandom_range(0, 31));
            im_req = im_pend; im_addr = 9'd11;
            if (im_gnt && first_im < 0) first_im = i;
            cycle_check();
        end
        check("starve_grant_cycle", 64'(first_im), 64'(LIM));
        cycle_begin(); idle_inputs(); cycle_check();
        step();

        // core_hold with a WB write in flight; release grants DM the same cycle.
        cycle_begin();
        core_hold = 1'b1; dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'h3; dm_addr = 9'd2; dm_wdata = 32'h1234_5678;
        im_req = 1'b1; im_addr = 9'd3; wb_set(1'b1, 8, 32'hCAFE_F00D, 4'hF);
        cycle_check();
        step();
        cycle_begin(); wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; core_hold = 1'b0; cycle_check();
        check("hold_release_dm", 64'(dm_gnt), 64'(1));
        cycle_begin(); dm_req = 1'b0; cycle_check();
        cycle_begin(); im_req = 1'b0; cycle_check();
        step();

        // Reset pulsed in the cycle after a DM read grant drops its response.
        cycle_begin(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'd3; cycle_check();
        mon_en = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        starve = 0;
        wb_ack_cyc = 1'b0;
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        mon_en = 1'b1;
        cycle_begin(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'd5; cycle_check();
        cycle_begin(); dm_req = 1'b0; cycle_check();
        step();

        // Randomized traffic.
        idle_inputs();
        for (int i = 0; i < 1500; i++) begin
            cycle_begin();
            drive_random();
            cycle_check();
        end
        cycle_begin(); idle_inputs(); cycle_check();
        repeat (3) step();
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
